// File: rtl/adc_scan_sched.sv
// adc_scan_sched: multi-channel ADC scan scheduler feeding the SPI ADC engine and the UART.
// Latency: tick->strc_o 2 clk, eoc_i->st_o 1 clk, eot_i(LSB)->next strc_o 2 clk.
// Backpressure: waits on eoc_i/eot_i handshakes; ticks arriving while busy are dropped and set ovr_o.
//
// Ports: clk_i/rst_i (sync, active-low); en_i, chmask_i, period_i scan control;
//        strc_o/cmd_o/eoc_i/dout_i SPI side; st_o/data_o/eot_i UART side;
//        ch_o, busy_o, eos_o, ovr_o status.
// Optional: define ADC_SCAN_HDR_EN to prefix every scan frame with an 8'hA5 header byte.
module adc_scan_sched #(
  parameter int          NCH    = 8,
  parameter int          TW     = 29,
  parameter logic [3:0]  CMD_LO = 4'b0111
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [7:0]    chmask_i,
  input  logic [TW-1:0] period_i,
  output logic          strc_o,
  output logic [7:0]    cmd_o,
  input  logic          eoc_i,
  input  logic [11:0]   dout_i,
  output logic          st_o,
  output logic [7:0]    data_o,
  input  logic          eot_i,
  output logic [2:0]    ch_o,
  output logic          busy_o,
  output logic          eos_o,
  output logic          ovr_o
);

  // Channels at or above NCH are never serviced.
  localparam logic [8:0] VM9   = (9'd1 << NCH) - 9'd1;
  localparam logic [7:0] VMASK = VM9[7:0];

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HWT, S_SEL, S_CONV, S_WEOC,
    S_TXM, S_WTM, S_TXL, S_WTL, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    mask_q, mask_d;
  logic [2:0]    ch_q, ch_d;
  logic [7:0]    dlo_q, dlo_d;
  logic [7:0]    data_q, data_d;
  logic          ovr_q, ovr_d;

  logic       tick;
  logic       strc, st, eos;
  logic [2:0] low_ch;
  logic [7:0] req_mask;

  always_comb begin
    tick     = en_i && (cnt_q == period_i);
    cnt_d    = (en_i && !tick) ? cnt_q + 1'b1 : '0;
    req_mask = chmask_i & VMASK;

    // Lowest set bit of the latched mask: scanning downward leaves the smallest index.
    low_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) low_ch = 3'(i);
    end

    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    dlo_d   = dlo_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    strc    = 1'b0;
    st      = 1'b0;
    eos     = 1'b0;

    if (tick && (state_q != S_IDLE)) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick && (req_mask != 8'd0)) begin
          mask_d = req_mask;
`ifdef ADC_SCAN_HDR_EN
          data_d  = 8'hA5;
          state_d = S_HDR;
`else
          state_d = S_SEL;
`endif
        end
      end
`ifdef ADC_SCAN_HDR_EN
      S_HDR: begin
        st      = 1'b1;
        state_d = S_HWT;
      end
      S_HWT: if (eot_i) state_d = S_SEL;
`endif
      S_SEL: begin
        ch_d    = low_ch;
        mask_d  = mask_q & (mask_q - 8'd1);  // drop the lowest set bit
        state_d = S_CONV;
      end
      S_CONV: begin
        strc    = 1'b1;
        state_d = S_WEOC;
      end
      S_WEOC: begin
        if (eoc_i) begin
          // MSB byte is staged here so it is already on data_o during the st_o cycle.
          data_d  = {ch_q, 1'b0, dout_i[11:8]};
          dlo_d   = dout_i[7:0];
          state_d = S_TXM;
        end
      end
      S_TXM: begin
        st      = 1'b1;
        state_d = S_WTM;
      end
      S_WTM: begin
        if (eot_i) begin
          data_d  = dlo_q;
          state_d = S_TXL;
        end
      end
      S_TXL: begin
        st      = 1'b1;
        state_d = S_WTL;
      end
      S_WTL: begin
        if (eot_i) state_d = (mask_q != 8'd0) ? S_SEL : S_DONE;
      end
      S_DONE: begin
        eos     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= 8'd0;
      ch_q    <= 3'd0;
      dlo_q   <= 8'd0;
      data_q  <= 8'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      dlo_q   <= dlo_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign strc_o = strc;
  assign st_o   = st;
  assign eos_o  = eos;
  assign cmd_o  = {1'b1, ch_q, CMD_LO};
  assign ch_o   = ch_q;
  assign data_o = data_q;
  assign busy_o = (state_q != S_IDLE);
  assign ovr_o  = ovr_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// tb_adc_scan_sched: scoreboard bench for adc_scan_sched with ADC and UART responders.
// Latency: n/a (bench).
// Backpressure: responders return eoc_i/eot_i after programmable delays.
module tb_adc_scan_sched;

  localparam int TW = 29;
`ifdef ADC_SCAN_HDR_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i, en_i, eoc_i, eot_i;
  logic [7:0]    chmask_i;
  logic [TW-1:0] period_i;
  logic [11:0]   dout_i;
  logic          strc_o, st_o, busy_o, eos_o, ovr_o;
  logic [7:0]    cmd_o, data_o;
  logic [2:0]    ch_o;

  adc_scan_sched #(.NCH(8), .TW(TW), .CMD_LO(4'b0111)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .chmask_i(chmask_i), .period_i(period_i),
    .strc_o(strc_o), .cmd_o(cmd_o), .eoc_i(eoc_i), .dout_i(dout_i),
    .st_o(st_o), .data_o(data_o), .eot_i(eot_i),
    .ch_o(ch_o), .busy_o(busy_o), .eos_o(eos_o), .ovr_o(ovr_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [11:0] dval [8];
  logic [2:0]  cmd_q  [$];
  logic [7:0]  byte_q [$];
  int          strc_t [$];
  int cyc = 0, n_strc = 0, n_st = 0, n_eos = 0, n_busy = 0;
  int adc_lat = 4, uart_lat = 6, adc_cnt = 0, uart_cnt = 0;
  logic [2:0] adc_ch = 3'd0;

  // Expected traffic for one scan of mask m, computed from the bench's own sample table.
  task automatic push_scan(input logic [7:0] m);
`ifdef ADC_SCAN_HDR_EN
    byte_q.push_back(8'hA5);
`endif
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        cmd_q.push_back(3'(c));
        byte_q.push_back({3'(c), 1'b0, dval[c][11:8]});
        byte_q.push_back(dval[c][7:0]);
      end
    end
  endtask

  // Monitor + ADC/UART responders, evaluated 1 time unit after each rising edge.
  initial begin
    eoc_i = 1'b0; eot_i = 1'b0; dout_i = 12'd0;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      eoc_i = 1'b0;
      eot_i = 1'b0;
      if (adc_cnt > 0) begin
        adc_cnt--;
        if (adc_cnt == 0) begin eoc_i = 1'b1; dout_i = dval[adc_ch]; end
      end
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) eot_i = 1'b1;
      end
      if (busy_o) n_busy++;
      if (eos_o) n_eos++;
      if (strc_o) begin
        n_strc++;
        strc_t.push_back(cyc);
        adc_cnt = adc_lat;
        adc_ch  = cmd_o[6:4];
        chk("strc_expected", 32'(cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) begin
          logic [2:0] ec;
          ec = cmd_q.pop_front();
          chk("cmd", cmd_o, {1'b1, ec, 4'b0111});
          chk("ch", ch_o, ec);
        end
      end
      if (st_o) begin
        n_st++;
        uart_cnt = uart_lat;
        chk("st_expected", 32'(byte_q.size() != 0), 1);
        if (byte_q.size() != 0) chk("uart_byte", data_o, byte_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    cmd_q.delete(); byte_q.delete(); strc_t.delete();
    n_strc = 0; n_st = 0; n_eos = 0; n_busy = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strc"}, strc_o, 0);
    chk({tag, "_st"},   st_o,   0);
    chk({tag, "_eos"},  eos_o,  0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ovr"},  ovr_o,  0);
    chk({tag, "_cmd"},  cmd_o,  8'h87);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_ch"},   ch_o,   0);
  endtask

  task automatic wait_eos(input int target, input int budget);
    for (int i = 0; i < budget && n_eos < target; i++) @(negedge clk_i);
    chk("eos_timeout", 32'(n_eos >= target), 1);
  endtask

  initial begin
    int base;
    dval[0] = 12'hABC; dval[1] = 12'h5E7; dval[2] = 12'h123; dval[3] = 12'h3C4;
    dval[4] = 12'h456; dval[5] = 12'h9A0; dval[6] = 12'h0FF; dval[7] = 12'hF0D;
    rst_i = 1'b0; en_i = 1'b0; chmask_i = 8'h00; period_i = '0;
    repeat (3) @(negedge clk_i);
    chk_reset_vals("rst");
    rst_i = 1'b1;

    // Two channels, two consecutive scans one period apart.
    do_reset();
    chmask_i = 8'h05; period_i = TW'(1000); adc_lat = 4; uart_lat = 6;
    push_scan(8'h05); push_scan(8'h05);
    en_i = 1'b1;
    for (int i = 0; i < 3000 && strc_t.size() < 3; i++) @(negedge clk_i);
    en_i = 1'b0;
    chk("strc_seen", 32'(strc_t.size() >= 3), 1);
    if (strc_t.size() >= 3) chk("tick_interval", 32'(strc_t[2] - strc_t[0]), 1001);
    wait_eos(2, 500);
    repeat (20) @(negedge clk_i);
    chk("t1_eos", n_eos, 2);
    chk("t1_busy", busy_o, 0);
    chk("t1_ovr", ovr_o, 0);
    chk("t1_bytes_left", byte_q.size(), 0);

    // Empty mask: ticks are ignored entirely.
    do_reset();
    chmask_i = 8'h00; period_i = TW'(50); en_i = 1'b1;
    repeat (160) @(negedge clk_i);
    en_i = 1'b0;
    chk("empty_strc", n_strc, 0);
    chk("empty_st", n_st, 0);
    chk("empty_eos", n_eos, 0);
    chk("empty_busy", n_busy, 0);

    // Overrun: slow UART, ticks land inside the scan.
    do_reset();
    chmask_i = 8'h01; period_i = TW'(50); adc_lat = 4; uart_lat = 500;
    push_scan(8'h01);
    en_i = 1'b1;
    for (int i = 0; i < 400 && !ovr_o; i++) @(negedge clk_i);
    chk("ovr_rise", ovr_o, 1);
    chk("ovr_busy", busy_o, 1);
    en_i = 1'b0;
    wait_eos(1, 4000);
    repeat (10) @(negedge clk_i);
    chk("ovr_sticky", ovr_o, 1);
    chk("ovr_eos", n_eos, 1);
    chk("ovr_bytes_left", byte_q.size(), 0);

    // en_i dropped while waiting for ch1 conversion.
    do_reset();
    chmask_i = 8'h03; period_i = TW'(20); adc_lat = 20; uart_lat = 5;
    push_scan(8'h03);
    en_i = 1'b1;
    for (int i = 0; i < 500 && n_strc < 2; i++) @(negedge clk_i);
    chk("endrop_ch1", 32'(n_strc >= 2), 1);
    en_i = 1'b0;
    wait_eos(1, 500);
    repeat (100) @(negedge clk_i);
    chk("endrop_eos", n_eos, 1);
    chk("endrop_strc", n_strc, 2);
    chk("endrop_bytes_left", byte_q.size(), 0);

    // Reset pulse while waiting for the MSB byte to finish.
    do_reset();
    chmask_i = 8'h03; period_i = TW'(20); adc_lat = 4; uart_lat = 30;
    push_scan(8'h03);
    en_i = 1'b1;
    for (int i = 0; i < 500 && n_st < HOFF + 1; i++) @(negedge clk_i);
    chk("wtm_reach", 32'(n_st >= HOFF + 1), 1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    chk_reset_vals("midrst");
    cmd_q.delete(); byte_q.delete();
    base = n_st;
    repeat (60) @(negedge clk_i);
    chk("midrst_no_st", n_st - base, 0);

    // Highest channel only.
    do_reset();
    chmask_i = 8'h80; period_i = TW'(60); adc_lat = 3; uart_lat = 4;
    push_scan(8'h80);
    en_i = 1'b1;
    wait_eos(1, 300);
    en_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("ch7_eos", n_eos, 1);
    chk("ch7_st", n_st, HOFF + 2);
    chk("ch7_bytes_left", byte_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
